// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word reads to instruction memory and
// buffers responses in a 2-entry {pc, instr} FIFO for the decoder.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   output logic            o_instr_valid,
   input  logic            i_instr_ready,
   output logic            o_fetch_err
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   state_t             state;
   state_t             state_nxt;
   logic [XLEN-1:0]    fetch_pc;
   logic [XLEN-1:0]    req_pc;
   logic               inflight;
   logic [CNT_W-1:0]   count;
   logic               head;
   logic               wr_idx;
   fetch_entry_t       fifo_q [DEPTH];

   logic               req;
   logic               push;
   logic               pop;
   logic               redirect_act;
   logic [OCC_W-1:0]   occupancy;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_RUN;
         S_RUN:   if (i_redirect) state_nxt = S_FLUSH;
         S_FLUSH: if (!i_redirect) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request, push and pop decisions; occupancy counts the word about to land
   always_comb begin
      redirect_act = 1'b0;
      push         = 1'b0;
      req          = 1'b0;
      pop          = o_instr_valid && i_instr_ready;
      occupancy    = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
      if (state != S_IDLE) begin
         redirect_act = i_redirect;
         push         = inflight && !i_redirect;
         req          = !i_redirect && (occupancy < OCC_W'(DEPTH));
      end
   end

   assign o_imem_req  = req;
   assign o_imem_addr = req ? fetch_pc : '0;

   assign wr_idx = head ^ count[0];

   // Fetch pointer, in-flight tracking and FIFO bookkeeping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         inflight    <= 1'b0;
         count       <= '0;
         head        <= 1'b0;
         o_fetch_err <= 1'b0;
      end else if (redirect_act) begin
         fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         inflight <= 1'b0;
         count    <= '0;
         head     <= 1'b0;
         if (|i_redirect_pc[1:0]) begin
            o_fetch_err <= 1'b1;
         end
      end else begin
         inflight <= req;
         if (req) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (pop) begin
            head <= ~head;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage; stale slots are masked by count
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_q[wr_idx].pc    <= req_pc;
         fifo_q[wr_idx].instr <= i_imem_rdata;
      end
   end

   assign o_instr_valid = (count != '0);
   assign o_instr       = o_instr_valid ? fifo_q[head].instr : '0;
   assign o_instr_pc    = o_instr_valid ? fifo_q[head].pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model for the default instance,
// closed-form prediction for a wrap-around instance with ready held high.
module tb_instr_fetch;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst_n;
   logic        ready0, redirect0;
   logic [31:0] redirect_pc0, rdata0, rdata1;
   logic        req0, valid0, err0, req1, valid1, err1;
   logic [31:0] addr0, instr0, ipc0, addr1, instr1, ipc1;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] salt;

   // Reference model state for dut0
   logic [31:0] mq_pc  [$];
   logic [31:0] mq_ins [$];
   bit          m_started, m_infl, m_err;
   logic [31:0] m_infl_pc, m_fpc;
   // Environment memory responses and observed deliveries
   bit          resp0_v, resp1_v;
   logic [31:0] resp0_a, resp1_a;
   logic [31:0] dlv [$];
   int          k1;
   logic [31:0] wrap_lit [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
   logic [31:0] rnd_pc;
   int          n0, n4;

   instr_fetch dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req(req0), .o_imem_addr(addr0), .i_imem_rdata(rdata0),
      .i_redirect(redirect0), .i_redirect_pc(redirect_pc0),
      .o_instr(instr0), .o_instr_pc(ipc0), .o_instr_valid(valid0),
      .i_instr_ready(ready0), .o_fetch_err(err0)
   );

   instr_fetch #(.RESET_PC(WRAP_PC)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_rdata(rdata1),
      .i_redirect(1'b0), .i_redirect_pc(32'h0),
      .o_instr(instr1), .o_instr_pc(ipc1), .o_instr_valid(valid1),
      .i_instr_ready(1'b1), .o_fetch_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ salt;
   endfunction

   function automatic logic [31:0] dlv_at(input int i);
      return (i < dlv.size()) ? dlv[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Assert reset mid-cycle, check async reset values, release after two edges
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req0", req0, 0);    chk("rst_addr0", addr0, 0);
      chk("rst_valid0", valid0, 0); chk("rst_instr0", instr0, 0);
      chk("rst_pc0", ipc0, 0);     chk("rst_err0", err0, 0);
      chk("rst_req1", req1, 0);    chk("rst_addr1", addr1, 0);
      chk("rst_valid1", valid1, 0); chk("rst_pc1", ipc1, 0);
      mq_pc.delete(); mq_ins.delete(); dlv.delete();
      m_started = 0; m_infl = 0; m_err = 0; m_fpc = 32'h0; m_infl_pc = 32'h0;
      resp0_v = 0; resp1_v = 0; k1 = 0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, compare against both models, advance models
   task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rdpc);
      bit          exp_v, exp_req, pop, e1_req, e1_v;
      logic [31:0] exp_pc, exp_ins, exp_addr, e1_pc;
      @(negedge clk);
      ready0 = rdy; redirect0 = rd; redirect_pc0 = rdpc;
      rdata0 = resp0_v ? word(resp0_a) : $urandom();
      rdata1 = resp1_v ? word(resp1_a) : $urandom();
      #1;
      exp_v   = (mq_pc.size() != 0);
      exp_pc  = exp_v ? mq_pc[0]  : 32'h0;
      exp_ins = exp_v ? mq_ins[0] : 32'h0;
      pop     = exp_v && rdy;
      if (!m_started || rd) exp_req = 0;
      else exp_req = (mq_pc.size() + int'(m_infl) - int'(pop)) < 2;
      exp_addr = exp_req ? m_fpc : 32'h0;
      chk("req", req0, exp_req);     chk("addr", addr0, exp_addr);
      chk("valid", valid0, exp_v);   chk("ipc", ipc0, exp_pc);
      chk("instr", instr0, exp_ins); chk("err", err0, m_err);
      if (valid0 && rdy) dlv.push_back(ipc0);
      if (!m_started) begin
         m_started = 1;
      end else if (rd) begin
         mq_pc.delete(); mq_ins.delete();
         m_infl = 0;
         m_fpc  = {rdpc[31:2], 2'b00};
         if (rdpc[1:0] != 2'b00) m_err = 1;
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
         end
         if (m_infl) begin
            mq_pc.push_back(m_infl_pc);
            mq_ins.push_back(rdata0);
         end
         m_infl    = exp_req;
         m_infl_pc = m_fpc;
         if (exp_req) m_fpc = m_fpc + 32'd4;
      end
      // Wrap instance: request every cycle from cycle 1, valid from cycle 3
      e1_req = (k1 >= 1);
      e1_v   = (k1 >= 3);
      e1_pc  = e1_v ? WRAP_PC + 32'(4 * (k1 - 3)) : 32'h0;
      chk("w_req", req1, e1_req);
      chk("w_addr", addr1, e1_req ? WRAP_PC + 32'(4 * (k1 - 1)) : 32'h0);
      chk("w_valid", valid1, e1_v);
      chk("w_pc", ipc1, e1_pc);
      chk("w_instr", instr1, e1_v ? word(e1_pc) : 32'h0);
      chk("w_err", err1, 0);
      if (k1 >= 3 && k1 <= 5) chk("wrap_seq", ipc1, wrap_lit[k1 - 3]);
      k1++;
      resp0_v = req0; resp0_a = addr0;
      resp1_v = req1; resp1_a = addr1;
   endtask

   initial begin
      rst_n = 1'b0; ready0 = 1'b0; redirect0 = 1'b0;
      redirect_pc0 = 32'h0; rdata0 = 32'h0; rdata1 = 32'h0;
      salt = $urandom();

      // Back-to-back fetch with ready high
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 0, 0);
      chk("A_dlv0", dlv_at(0), 32'h0);
      chk("A_dlv1", dlv_at(1), 32'h4);
      chk("A_dlv2", dlv_at(2), 32'h8);

      // Decoder stall from cycle 3: two entries buffered, then drained in order
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      chk("B_stalled", 32'(dlv.size()), 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0);
      chk("B_dlv0", dlv_at(0), 32'h0);
      chk("B_dlv1", dlv_at(1), 32'h4);
      chk("B_dlv2", dlv_at(2), 32'h8);

      // Redirect while 0x8 is buffered and 0xC is arriving
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0, 0);
      cyc(0, 1, 32'h100);
      n0 = dlv.size();
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      chk("C_prev", dlv_at(n0 - 1), 32'h4);
      chk("C_next", dlv_at(n0), 32'h100);

      // Redirect followed by a misaligned one in FLUSH: latest wins, error sticks
      cyc(1, 1, 32'h300);
      cyc(1, 1, 32'h203);
      n0 = dlv.size();
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      chk("D_next", dlv_at(n0), 32'h200);
      chk("D_err", err0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0);
      chk("D_err_sticky", err0, 1);

      // Redirect in the same cycle as the handshake of pc 0x4
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 0, 0);
      cyc(1, 1, 32'h40);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0);
      n4 = 0;
      foreach (dlv[i]) if (dlv[i] == 32'h4) n4++;
      chk("E_once", 32'(n4), 1);
      chk("E_dlv1", dlv_at(1), 32'h4);
      chk("E_dlv2", dlv_at(2), 32'h40);

      // Random traffic with occasional (sometimes misaligned) redirects
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rnd_pc = $urandom();
         if ($urandom_range(0, 3) != 0) rnd_pc[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) rnd_pc = 32'hFFFF_FFF4;
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rnd_pc);
      end

      // Reset mid-stream, then restart from RESET_PC
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      chk("G_dlv0", dlv_at(0), 32'h0);
      chk("G_dlv1", dlv_at(1), 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
